// File: rtl/logic_op_arbiter.sv
// Round-robin shared bitwise logic unit (AND/OR/XOR/NOR) for two requesters.
// One result is held at a time; a response handshake and a new accept may share an edge.
module logic_op_arbiter #(
  parameter int W    = 32,
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_op,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_op,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  output logic            req1_ready,
  output logic            rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_id,
  input  logic            rsp_ready
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t         r_state;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_data;
  logic           r_rsp_id;
  logic           r_last;

  logic           w_can;
  logic [1:0]     w_gnt;
  logic           w_sel;
  logic [OP_W-1:0] w_op;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [W-1:0]   w_res;

  function automatic logic [W-1:0] f_logic(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      2'b00:   f_logic = a & b;
      2'b01:   f_logic = a | b;
      2'b10:   f_logic = a ^ b;
      default: f_logic = ~(a | b);
    endcase
  endfunction

  // Ready never depends on op/operands; it is forced low during reset.
  assign w_can    = !rst && ((r_state == S_IDLE) || rsp_ready);
  assign w_gnt[0] = w_can && req0_valid && (!req1_valid || r_last);
  assign w_gnt[1] = w_can && req1_valid && (!req0_valid || !r_last);
  assign w_sel    = w_gnt[1];

  assign w_op  = w_sel ? req1_op : req0_op;
  assign w_a   = w_sel ? req1_a  : req0_a;
  assign w_b   = w_sel ? req1_b  : req0_b;
  assign w_res = f_logic(w_op[1:0], w_a, w_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_last      <= 1'b1;
    end else if (|w_gnt) begin
      r_state     <= S_RESP;
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_res;
      r_rsp_id    <= w_sel;
      r_last      <= w_sel;
    end else if (r_state == S_RESP && rsp_ready) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
    end
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed plus randomized bench for logic_op_arbiter against a rule-level model.
module tb_logic_op_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  logic_op_arbiter #(.W(32), .OP_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference state: is a result held, what it is, who owns it, who won last.
  bit          m_held;
  logic [31:0] m_data;
  bit          m_id;
  bit          m_last;
  bit          m_g0, m_g1;
  logic        s_rdy0, s_rdy1;

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Inputs are set after a falling edge; sample, check, then advance one cycle.
  task automatic step();
    bit can;
    #1;
    can  = !rst && (!m_held || rsp_ready);
    m_g0 = can && req0_valid && (!req1_valid || m_last);
    m_g1 = can && req1_valid && (!req0_valid || !m_last);
    s_rdy0 = req0_ready;
    s_rdy1 = req1_ready;
    chk("rdy0", {31'd0, req0_ready}, {31'd0, m_g0});
    chk("rdy1", {31'd0, req1_ready}, {31'd0, m_g1});
    chk("vld", {31'd0, rsp_valid}, {31'd0, m_held});
    if (m_held) begin
      chk("data", rsp_data, m_data);
      chk("id", {31'd0, rsp_id}, {31'd0, m_id});
    end
    @(posedge clk);
    if (rst) begin
      m_held = 0; m_data = 0; m_id = 0; m_last = 1;
    end else if (m_g0) begin
      m_held = 1; m_data = ref_op(req0_op, req0_a, req0_b); m_id = 0; m_last = 0;
    end else if (m_g1) begin
      m_held = 1; m_data = ref_op(req1_op, req1_a, req1_b); m_id = 1; m_last = 1;
    end else if (m_held && rsp_ready) begin
      m_held = 0;
    end
    @(negedge clk);
  endtask

  task automatic rnd0(); req0_op = 2'($urandom); req0_a = $urandom; req0_b = $urandom; endtask
  task automatic rnd1(); req1_op = 2'($urandom); req1_a = $urandom; req1_b = $urandom; endtask

  logic [31:0] t2_exp [4];
  logic [31:0] snap_d;
  logic        snap_id;

  initial begin
    t2_exp[0] = 32'hFF00_0000; t2_exp[1] = 32'hFFFF_FF00;
    t2_exp[2] = 32'h00FF_FF00; t2_exp[3] = 32'h0000_00FF;
    m_held = 0; m_data = 0; m_id = 0; m_last = 1;
    rst = 1; rsp_ready = 1; req0_valid = 1; req1_valid = 1;
    rnd0(); rnd1();
    @(negedge clk);
    step(); step();
    rst = 0; req0_valid = 0; req1_valid = 0;
    chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);

    // single OR on port 0
    req0_valid = 1; req0_op = 2'b01; req0_a = 32'hF0F0_0000; req0_b = 32'h0000_0F0F;
    step();
    chk("t1_rdy", {31'd0, s_rdy0}, 32'd1);
    req0_valid = 0;
    chk("t1_vld", {31'd0, rsp_valid}, 32'd1);
    chk("t1_data", rsp_data, 32'hF0F0_0F0F);
    chk("t1_id", {31'd0, rsp_id}, 32'd0);

    // all opcodes on port 1
    for (int k = 0; k < 4; k++) begin
      req1_valid = 1; req1_op = 2'(k); req1_a = 32'hFFFF_0000; req1_b = 32'hFF00_FF00;
      step();
      chk("t2_rdy", {31'd0, s_rdy1}, 32'd1);
      req1_valid = 0;
      chk("t2_data", rsp_data, t2_exp[k]);
      chk("t2_id", {31'd0, rsp_id}, 32'd1);
    end
    step();

    // tie from reset alternates starting with port 0
    rst = 1; step(); rst = 0;
    req0_valid = 1; req1_valid = 1; rnd0(); rnd1();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_g0", {31'd0, s_rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_g1", {31'd0, s_rdy1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_id", {31'd0, rsp_id}, 32'(i % 2));
      if (s_rdy0) rnd0();
      if (s_rdy1) rnd1();
    end

    // back-pressure with port 1 waiting
    req0_valid = 0; req1_valid = 1; rnd1(); rsp_ready = 0;
    snap_d = rsp_data; snap_id = rsp_id;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_rdy1", {31'd0, s_rdy1}, 32'd0);
      chk("t4_hold_d", rsp_data, snap_d);
      chk("t4_hold_id", {31'd0, rsp_id}, {31'd0, snap_id});
      chk("t4_vld", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1;
    step();
    chk("t4_acc", {31'd0, s_rdy1}, 32'd1);
    req1_valid = 0;
    chk("t4_res", rsp_data, ref_op(req1_op, req1_a, req1_b));
    chk("t4_resid", {31'd0, rsp_id}, 32'd1);

    // reset while a result is stalled
    rsp_ready = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("t5_vld", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1; req0_valid = 1; req1_valid = 1; rnd0(); rnd1();
    step();
    chk("t5_tie", {31'd0, s_rdy0}, 32'd1);
    req0_valid = 0; req1_valid = 0;

    // port 1 withdraws under back-pressure; pointer stays on port 0's win
    rsp_ready = 0; req1_valid = 1; rnd1();
    step(); step();
    req1_valid = 0; rsp_ready = 1;
    step();
    chk("t6_idle", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1; req1_valid = 1; rnd0(); rnd1();
    step();
    chk("t6_tie", {31'd0, s_rdy1}, 32'd1);
    chk("t6_id", {31'd0, rsp_id}, 32'd1);
    req0_valid = 0; req1_valid = 0;

    // randomized traffic obeying the hold-until-ready rule
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid || m_g0) begin
        req0_valid = ($urandom_range(0, 2) != 0); rnd0();
      end else if ($urandom_range(0, 15) == 0) req0_valid = 0;
      if (!req1_valid || m_g1) begin
        req1_valid = ($urandom_range(0, 2) != 0); rnd1();
      end else if ($urandom_range(0, 15) == 0) req1_valid = 0;
      step();
      chk("one_hot", {31'd0, s_rdy0 & s_rdy1}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters in the pipelined CPU: the EX stage (port 0) and the CSR/debug path (port 1). It uses round-robin arbitration, one outstanding operation at a time, and a registered result with a valid/ready response handshake. The result is tagged with the requester ID so the consumer can steer it.

## Interface
Parameters:
- W, 32, operand/result width
- OP_W, 2, opcode width (fixed encoding below)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_op  in  OP_W  port 0 opcode
- req0_a, req0_b  in  W  port 0 operands
- req0_ready  out  1  port 0 request accepted this cycle
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for port 1
- rsp_valid  out  1  result held and valid
- rsp_data  out  W  result
- rsp_id  out  1  requester of current result (0/1)
- rsp_ready  in  1  consumer takes result this cycle

## Operation
- Opcode encoding: 00 = A&B, 01 = A|B, 10 = A^B, 11 = ~(A|B). All ops are bitwise with no carry, and every result is exactly W bits.
- FSM states:
  - IDLE: no result held.
  - RESP: result held, rsp_valid=1.
- Accept condition: `can_accept = (state==IDLE) || (state==RESP && rsp_ready)`.
- Grant rules (combinational, only when can_accept):
  - Only one valid requester: grant it.
  - Both valid: grant the port that is not `last_grant`.
  - reqN_ready = can_accept && grant==N. At most one ready is high per cycle.
- On accept (reqN_valid && reqN_ready):
  - rsp_data <= f(op, a, b), rsp_id <= N, last_grant <= N, state <= RESP.
- In RESP with rsp_ready=1 and no accept: state <= IDLE. rsp_data/rsp_id keep their last values but are don't-care.
- In RESP with rsp_ready=0:
  - Hold rsp_data, rsp_id and rsp_valid stable.
  - Both reqN_ready stay 0, and last_grant is unchanged.
- Requesters must hold valid/op/a/b stable until ready. A requester may drop valid before ready, and no grant is recorded in that case.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (port 0 wins the first tie), req0_ready=req1_ready=0 while rst=1.

## Timing
- Latency: request accepted at edge N; rsp_valid=1 with the result visible in the cycle after edge N.
- Throughput: one operation per cycle while rsp_ready=1 continuously. A response handshake and a new accept happen at the same edge.
- reqN_ready depends combinationally on rsp_ready, state and the valids. It has no dependence on op or the operands.
- Back-pressure: rsp_ready=0 stalls both ports with no loss and no duplication.
- Reset mid-operation: a held result is discarded and rsp_valid=0 in the next cycle. Any request presented in the reset cycle is not accepted.
- Fairness: with both ports valid continuously and rsp_ready=1, grants alternate 0,1,0,1… A single continuously valid port receives every grant.

## Test plan
- Reset then a single op:
  - Stimulus: req0 op=01, a=0xF0F0_0000, b=0x0000_0F0F, rsp_ready=1.
  - Response: req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_data=0xF0F0_0F0F, rsp_id=0.
- All opcodes on port 1:
  - Stimulus: a=0xFFFF_0000, b=0xFF00_FF00.
  - Response: AND=0xFF00_0000, OR=0xFFFF_FF00, XOR=0x00FF_FF00, NOR=0x0000_00FF, all with rsp_id=1.
- Tie and round-robin:
  - Stimulus: both valid from reset for 4 cycles, rsp_ready=1.
  - Response: grants 0,1,0,1; rsp_id sequence 0,1,0,1 with one-cycle lag; never two readys in one cycle.
- Back-pressure:
  - Stimulus: result pending, hold rsp_ready=0 for 3 cycles while req1 is valid.
  - Response: rsp_data/rsp_id stable; req1_ready=0 throughout; when rsp_ready=1, req1 is accepted at that same edge and its result appears the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle while in RESP with rsp_ready=0.
  - Response: rsp_valid=0 after the reset edge; the next tie is granted to port 0.
- Valid withdrawn:
  - Stimulus: req1 valid during back-pressure, then dropped before ready.
  - Response: no req1 result; last_grant is unchanged and the next tie follows the prior pointer.
